// File: rtl/mems_dac_spi_slave.sv
// mems_dac_spi_slave: receive side of the 24-bit MEMS driver SPI link.
// Oversamples sck/mosi/cs_n on clk and deframes each chip-select window.
// Each good frame is decoded as an AD5664-style DAC command that updates
// four 16-bit input/output channel register pairs.
module mems_dac_spi_slave #(
   parameter int WORD_BITS   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sck,
   input  logic                 mosi,
   input  logic                 cs_n,
   output logic [WORD_BITS-1:0] data_out,
   output logic                 new_data,
   output logic                 frame_error,
   output logic                 busy,
   output logic [2:0]           cmd,
   output logic [2:0]           addr,
   output logic [15:0]          ch0,
   output logic [15:0]          ch1,
   output logic [15:0]          ch2,
   output logic [15:0]          ch3
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_CLOSE = 2'd2;

   logic [SYNC_STAGES-1:0] sck_sq, mosi_sq, cs_sq;
   logic [SYNC_STAGES:0]   fill_q;
   logic                   sck_d1_q, cs_d1_q;
   logic                   sck_s, mosi_s, cs_s, sync_ok;
   logic                   sck_fall, cs_fall, cs_rise;

   logic [1:0]             state_q, state_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [WORD_BITS-1:0]   sr_q, sr_d;

   logic [WORD_BITS-1:0]   data_out_q;
   logic                   new_data_q, frame_error_q;
   logic [2:0]             cmd_q, addr_q;
   logic [3:0][15:0]       in_q, ch_q;

   logic                   frame_ok;
   logic [2:0]             f_cmd, f_addr;
   logic [15:0]            f_data;
   logic [3:0]             sel;

   assign sck_s  = sck_sq[SYNC_STAGES-1];
   assign mosi_s = mosi_sq[SYNC_STAGES-1];
   assign cs_s   = cs_sq[SYNC_STAGES-1];
   // Chain contents are only trusted once real pin samples have reached
   // the delayed copy; this keeps a cs_n held low through reset release
   // from looking like a fresh falling edge.
   assign sync_ok  = fill_q[SYNC_STAGES];
   assign sck_fall = sck_d1_q & ~sck_s;
   assign cs_fall  = sync_ok & cs_d1_q & ~cs_s;
   assign cs_rise  = ~cs_d1_q & cs_s;

   // Input synchronizers, delayed copies for edge detection, fill tracker
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sq   <= '0;
         mosi_sq  <= '0;
         cs_sq    <= '1;
         fill_q   <= '0;
         sck_d1_q <= 1'b0;
         cs_d1_q  <= 1'b1;
      end else begin
         sck_sq   <= {sck_sq[SYNC_STAGES-2:0], sck};
         mosi_sq  <= {mosi_sq[SYNC_STAGES-2:0], mosi};
         cs_sq    <= {cs_sq[SYNC_STAGES-2:0], cs_n};
         fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
         sck_d1_q <= sck_s;
         cs_d1_q  <= cs_s;
      end
   end

   // Framing FSM next state; a cs_n rise wins over a coincident sck fall
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            sr_d  = '0;
            if (cs_fall) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (cs_rise) begin
               state_d = S_CLOSE;
            end else if (sck_fall) begin
               sr_d = {sr_q[WORD_BITS-2:0], mosi_s};
               if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
            end
         end
         S_CLOSE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Framing FSM state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end

   assign frame_ok = (state_q == S_CLOSE) && (cnt_q == 5'(WORD_BITS));
   assign f_cmd    = sr_q[21:19];
   assign f_addr   = sr_q[18:16];
   assign f_data   = sr_q[15:0];

   // Channel select: 0-3 one-hot, 7 broadcast, 4-6 nothing
   always_comb begin
      sel = '0;
      if (f_addr == 3'b111)  sel = 4'hF;
      else if (!f_addr[2])   sel[f_addr[1:0]] = 1'b1;
   end

   // Frame close: publish the word and execute the DAC command, or flag error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q    <= '0;
         new_data_q    <= 1'b0;
         frame_error_q <= 1'b0;
         cmd_q         <= '0;
         addr_q        <= '0;
         in_q          <= '0;
         ch_q          <= '0;
      end else begin
         new_data_q    <= 1'b0;
         frame_error_q <= 1'b0;
         if (state_q == S_CLOSE) begin
            if (frame_ok) begin
               data_out_q <= sr_q;
               new_data_q <= 1'b1;
               cmd_q      <= f_cmd;
               addr_q     <= f_addr;
               for (int i = 0; i < 4; i++) begin
                  case (f_cmd)
                     3'b000: if (sel[i]) in_q[i] <= f_data;
                     3'b001: if (sel[i]) ch_q[i] <= in_q[i];
                     3'b010: if (sel != 4'h0) begin
                        in_q[i] <= sel[i] ? f_data : in_q[i];
                        ch_q[i] <= sel[i] ? f_data : in_q[i];
                     end
                     3'b011: if (sel[i]) begin
                        in_q[i] <= f_data;
                        ch_q[i] <= f_data;
                     end
                     default: ;
                  endcase
               end
            end else begin
               frame_error_q <= 1'b1;
            end
         end
      end
   end

   assign data_out    = data_out_q;
   assign new_data    = new_data_q;
   assign frame_error = frame_error_q;
   assign busy        = ~cs_s;
   assign cmd         = cmd_q;
   assign addr        = addr_q;
   assign ch0         = ch_q[0];
   assign ch1         = ch_q[1];
   assign ch2         = ch_q[2];
   assign ch3         = ch_q[3];

endmodule

// File: tb/tb_mems_dac_spi_slave.sv
// Directed bench for mems_dac_spi_slave: frames driven bit-by-bit on the
// pins with hand-computed expected register contents.
module tb_mems_dac_spi_slave;

   localparam time HALF = 300ns; // ~1.6 MHz sck

   logic        clk = 1'b0;
   logic        rst_n, sck, mosi, cs_n;
   logic [23:0] data_out;
   logic        new_data, frame_error, busy;
   logic [2:0]  cmd, addr;
   logic [15:0] ch0, ch1, ch2, ch3;

   int errors = 0;
   int checks = 0;
   int nd_cnt = 0, fe_cnt = 0, both_cnt = 0;

   mems_dac_spi_slave #(.WORD_BITS(24), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .cs_n(cs_n),
      .data_out(data_out), .new_data(new_data), .frame_error(frame_error),
      .busy(busy), .cmd(cmd), .addr(addr),
      .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3)
   );

   always #10ns clk = ~clk;

   always @(negedge clk) begin
      if (new_data)                nd_cnt++;
      if (frame_error)             fe_cnt++;
      if (new_data && frame_error) both_cnt++;
   end

   task automatic shift_bits(input logic [31:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         mosi = w[i];
         sck  = 1'b1; #(HALF);
         sck  = 1'b0; #(HALF);
      end
   endtask

   // Full frame of n bits, MSB first; lat = clk cycles from cs_n rise to a pulse
   task automatic do_frame(input logic [31:0] w, input int n, output int lat);
      @(negedge clk); cs_n = 1'b0;
      #(HALF);
      shift_bits(w, n-1, 0);
      @(negedge clk); cs_n = 1'b1;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (new_data || frame_error) begin lat = k; break; end
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (data_out !== 24'h0) begin errors++; $display("FAIL reset_data_out got %h want 000000", data_out); end
      checks++; if ({cmd, addr} !== 6'h0) begin errors++; $display("FAIL reset_cmd_addr got %h want 00", {cmd, addr}); end
      checks++; if ({ch0, ch1, ch2, ch3} !== 64'h0) begin errors++; $display("FAIL reset_ch got %h want 0", {ch0, ch1, ch2, ch3}); end
      checks++; if ({new_data, frame_error, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {new_data, frame_error, busy}); end
   endtask

   task automatic test_write_update;
      int lat, nd0;
      nd0 = nd_cnt;
      do_frame(32'h181234, 24, lat);
      checks++; if (lat < 3 || lat > 5) begin errors++; $display("FAIL close_latency got %0d want 3..5", lat); end
      checks++; if (nd_cnt - nd0 !== 1) begin errors++; $display("FAIL write_nd_pulses got %0d want 1", nd_cnt - nd0); end
      checks++; if (data_out !== 24'h181234) begin errors++; $display("FAIL write_data_out got %h want 181234", data_out); end
      checks++; if ({cmd, addr} !== {3'd3, 3'd0}) begin errors++; $display("FAIL write_cmd_addr got %0d/%0d want 3/0", cmd, addr); end
      checks++; if ({ch0, ch1, ch2, ch3} !== {16'h1234, 48'h0}) begin errors++; $display("FAIL write_ch got %h want 1234000000000000", {ch0, ch1, ch2, ch3}); end
   endtask

   task automatic test_load_then_update;
      int lat;
      do_frame(32'h01ABCD, 24, lat);
      checks++; if (ch1 !== 16'h0) begin errors++; $display("FAIL load_ch1 got %h want 0000", ch1); end
      do_frame(32'h090000, 24, lat);
      checks++; if (ch1 !== 16'hABCD) begin errors++; $display("FAIL update_ch1 got %h want abcd", ch1); end
      checks++; if (ch0 !== 16'h1234) begin errors++; $display("FAIL update_ch0 got %h want 1234", ch0); end
   endtask

   task automatic test_broadcast;
      int lat;
      do_frame(32'h1F5555, 24, lat);
      checks++; if ({ch0, ch1, ch2, ch3} !== {4{16'h5555}}) begin errors++; $display("FAIL broadcast_ch got %h want 5555 x4", {ch0, ch1, ch2, ch3}); end
      checks++; if (addr !== 3'd7) begin errors++; $display("FAIL broadcast_addr got %0d want 7", addr); end
   endtask

   task automatic test_bad_lengths;
      int lat, nd0, fe0;
      nd0 = nd_cnt; fe0 = fe_cnt;
      do_frame(32'h18_0001, 23, lat);
      checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL len23_fe got %0d want 1", fe_cnt - fe0); end
      do_frame(32'h1_8000_02, 25, lat);
      checks++; if (lat < 3 || lat > 5) begin errors++; $display("FAIL len25_latency got %0d want 3..5", lat); end
      checks++; if (fe_cnt - fe0 !== 2) begin errors++; $display("FAIL len25_fe got %0d want 2", fe_cnt - fe0); end
      checks++; if (nd_cnt !== nd0) begin errors++; $display("FAIL badlen_nd got %0d want 0", nd_cnt - nd0); end
      checks++; if (data_out !== 24'h1F5555) begin errors++; $display("FAIL badlen_data_out got %h want 1f5555", data_out); end
      checks++; if ({ch0, ch1, ch2, ch3} !== {4{16'h5555}}) begin errors++; $display("FAIL badlen_ch got %h want 5555 x4", {ch0, ch1, ch2, ch3}); end
   endtask

   task automatic test_busy_empty;
      int fe0;
      fe0 = fe_cnt;
      @(negedge clk); cs_n = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_low_cs got %b want 1", busy); end
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_high_cs got %b want 0", busy); end
      checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL empty_frame_fe got %0d want 1", fe_cnt - fe0); end
   endtask

   task automatic test_idle_sck;
      int lat, nd0, fe0;
      nd0 = nd_cnt; fe0 = fe_cnt;
      shift_bits(32'h3FF, 9, 0);
      repeat (5) @(negedge clk);
      do_frame(32'h1A0F0F, 24, lat);
      checks++; if (nd_cnt - nd0 !== 1 || fe_cnt !== fe0) begin errors++; $display("FAIL idle_sck_pulses got nd=%0d fe=%0d want 1/0", nd_cnt - nd0, fe_cnt - fe0); end
      checks++; if ({ch0, ch1, ch2, ch3} !== {16'h5555, 16'h5555, 16'h0F0F, 16'h5555}) begin errors++; $display("FAIL idle_sck_ch got %h want 5555 5555 0f0f 5555", {ch0, ch1, ch2, ch3}); end
   endtask

   task automatic test_commands;
      int lat, nd0;
      // load ch3's input only; output must hold
      do_frame(32'h037777, 24, lat);
      checks++; if (ch3 !== 16'h5555) begin errors++; $display("FAIL load_ch3 got %h want 5555", ch3); end
      // write ch0 input and update all outputs
      do_frame(32'h101111, 24, lat);
      checks++; if ({ch0, ch1, ch2, ch3} !== {16'h1111, 16'h5555, 16'h0F0F, 16'h7777}) begin errors++; $display("FAIL upd_all_ch got %h want 1111 5555 0f0f 7777", {ch0, ch1, ch2, ch3}); end
      // cmd 100 broadcast: decoded, no register change
      nd0 = nd_cnt;
      do_frame(32'h27BEEF, 24, lat);
      checks++; if (nd_cnt - nd0 !== 1 || {cmd, addr} !== {3'd4, 3'd7}) begin errors++; $display("FAIL nop_cmd got nd=%0d cmd=%0d addr=%0d want 1/4/7", nd_cnt - nd0, cmd, addr); end
      // addr 100 selects nothing
      do_frame(32'h1C9999, 24, lat);
      checks++; if ({ch0, ch1, ch2, ch3} !== {16'h1111, 16'h5555, 16'h0F0F, 16'h7777}) begin errors++; $display("FAIL nosel_ch got %h want 1111 5555 0f0f 7777", {ch0, ch1, ch2, ch3}); end
      checks++; if (data_out !== 24'h1C9999) begin errors++; $display("FAIL nosel_data_out got %h want 1c9999", data_out); end
   endtask

   task automatic test_reset_midframe;
      int lat, nd0, fe0;
      logic [31:0] w;
      w = 32'h18ABCD;
      @(negedge clk); cs_n = 1'b0;
      #(HALF);
      shift_bits(w, 23, 12);
      @(negedge clk); rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (data_out !== 24'h0 || ch0 !== 16'h0) begin errors++; $display("FAIL midreset_clear got %h/%h want 0/0", data_out, ch0); end
      rst_n = 1'b1;
      nd0 = nd_cnt; fe0 = fe_cnt;
      shift_bits(w, 11, 0);
      @(negedge clk); cs_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (nd_cnt !== nd0 || fe_cnt !== fe0) begin errors++; $display("FAIL midreset_partial got nd=%0d fe=%0d want 0/0", nd_cnt - nd0, fe_cnt - fe0); end
      do_frame(32'h182468, 24, lat);
      checks++; if (nd_cnt - nd0 !== 1 || data_out !== 24'h182468 || ch0 !== 16'h2468) begin errors++; $display("FAIL midreset_next got nd=%0d data=%h ch0=%h want 1/182468/2468", nd_cnt - nd0, data_out, ch0); end
   endtask

   initial begin
      test_reset();
      test_write_update();
      test_load_then_update();
      test_broadcast();
      test_bad_lengths();
      test_busy_empty();
      test_idle_sck();
      test_commands();
      test_reset_midframe();
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", both_cnt); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
